title_bitmap_anim: RTL
======================

TITLE_BITMAP_ANIM -- requirements
Module: title_bitmap_anim

Interface
REQ-001 SHALL have parameter WIDTH, default 128, bitmap columns (1..256).
REQ-002 SHALL have parameter HEIGHT, default 16, bitmap rows (1..64).
REQ-003 SHALL have parameter SCALE_SHIFT, default 0, pixel magnification 2^SCALE_SHIFT (0..3).
REQ-004 SHALL have parameter BITMAP, default all ones, WIDTH*HEIGHT bits, row 0 first, column 0 MSB of each row; 0 = draw, 1 = transparent.
REQ-005 SHALL have parameter COLOR, default 8'hFF, base draw colour.
REQ-006 SHALL have parameter BLINK_ON / BLINK_PERIOD, default 20 / 40, frames visible / blink cycle length.
REQ-007 SHALL have parameter REVEAL_STEP, default 4, columns revealed per frame.
REQ-008 SHALL have parameter HUE_PERIOD, default 8, frames per colour step.
REQ-009 clk  in  1  system clock; all logic on rising edge.
REQ-010 reset  in  1  synchronous, active-high reset.
REQ-011 offsetX  in  11  pixel X offset from rectangle top-left.
REQ-012 offsetY  in  11  pixel Y offset from rectangle top-left.
REQ-013 InsideRectangle  in  1  current pixel lies in the object bracket.
REQ-014 startOfFrame  in  1  one-cycle pulse per video frame.
REQ-015 mode  in  2  0 static, 1 blink, 2 reveal wipe, 3 colour cycle.
REQ-016 drawingRequest  out  1  pixel shall be displayed.
REQ-017 RGBout  out  8  registered pixel colour; 8'h00 = transparent.
REQ-018 animDone  out  1  reveal wipe complete (mode 2 only).

Function
REQ-019 Column index SHALL be offsetX >> SCALE_SHIFT, row index offsetY >> SCALE_SHIFT; index >= WIDTH or >= HEIGHT SHALL give transparent.
REQ-020 RGBout SHALL be registered with one clk latency from offsetX/offsetY/InsideRectangle; InsideRectangle=0 SHALL give 8'h00.
REQ-021 drawingRequest SHALL be combinational: 1 iff RGBout != 8'h00.
REQ-022 Bitmap bit 1 SHALL give 8'h00; bit 0 SHALL give the current draw colour subject to REQ-023..027.
REQ-023 frameCnt (8 bit) SHALL increment on startOfFrame and wrap to 0 when reaching BLINK_PERIOD-1; mode 1 SHALL force transparent while frameCnt >= BLINK_ON.
REQ-024 Reveal FSM states IDLE, RUN, DONE; IDLE->RUN on mode becoming 2 (revealCol := 0); RUN: each startOfFrame revealCol += REVEAL_STEP, saturating at WIDTH; RUN->DONE when revealCol reaches WIDTH; DONE holds until mode leaves 2 (->IDLE).
REQ-025 In mode 2, columns >= revealCol SHALL be transparent; animDone SHALL be 1 only in DONE.
REQ-026 Mode 3: hueIdx (3 bit) SHALL advance once per HUE_PERIOD startOfFrame pulses, wrapping 7->0; colour = COLOR + {hueIdx,5'b0} mod 256; a result of 8'h00 SHALL be replaced by COLOR.
REQ-027 Any mode change SHALL clear frameCnt, hueIdx and the frame divider on the same edge; counters not used by the active mode SHALL hold.
REQ-028 startOfFrame coincident with a mode change SHALL be ignored for counting; the new mode begins from cleared counters.
REQ-029 Mode 0 SHALL draw the bitmap in COLOR with no animation.

Reset
REQ-030 reset=1 SHALL on the next edge set RGBout=8'h00, animDone=0, FSM=IDLE, revealCol=0, frameCnt=0, hueIdx=0, divider=0, and captured mode=0.
REQ-031 reset SHALL take priority over startOfFrame and mode change; reset mid-reveal SHALL restart the wipe from column 0 once released with mode=2.

Verification
REQ-032 Mode 0, WIDTH=128, pixel (0,0) bit 0, InsideRectangle=1 -> next cycle RGBout=8'hFF, drawingRequest=1; InsideRectangle=0 -> RGBout=8'h00.
REQ-033 SCALE_SHIFT=1, offsetX=256 (index 128 >= WIDTH) -> RGBout=8'h00.
REQ-034 Mode 1, 40 startOfFrame pulses -> drawn during frames 0..19, transparent frames 20..39, visible again at frame 40.
REQ-035 Mode 2, REVEAL_STEP=4, WIDTH=128 -> after 3 frames column 11 drawn, column 12 transparent; after 32 frames animDone=1; mode->0 -> animDone=0.
REQ-036 Mode 3, HUE_PERIOD=8, COLOR=8'hFF -> after 8 frames colour 8'h1F; hueIdx wraps after 64 frames; colour never 8'h00.
REQ-037 reset asserted at frame 10 of a reveal -> next cycle animDone=0, RGBout=8'h00; wipe restarts from column 0.

Source files
------------

// File: rtl/title_bitmap_anim.sv
// Title bitmap sprite with four display modes: static, blink, left-to-right
// reveal wipe and colour cycling. Pixel colour is registered one cycle after
// the pixel coordinates; drawingRequest is derived from the registered colour.
module title_bitmap_anim #(
  parameter int               WIDTH        = 128,
  parameter int               HEIGHT       = 16,
  parameter int               SCALE_SHIFT  = 0,
  parameter logic [WIDTH*HEIGHT-1:0] BITMAP = '1,
  parameter logic [7:0]       COLOR        = 8'hFF,
  parameter int               BLINK_ON     = 20,
  parameter int               BLINK_PERIOD = 40,
  parameter int               REVEAL_STEP  = 4,
  parameter int               HUE_PERIOD   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] offsetX,
  input  logic [10:0] offsetY,
  input  logic        InsideRectangle,
  input  logic        startOfFrame,
  input  logic [1:0]  mode,
  output logic        drawingRequest,
  output logic [7:0]  RGBout,
  output logic        animDone
);

  localparam int NB = WIDTH * HEIGHT;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [8:0]  reveal_col_q, reveal_col_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [7:0]  div_q, div_d;
  logic [2:0]  hue_q, hue_d;
  logic [7:0]  rgb_q, rgb_d;

  logic        mode_chg, sof;
  logic [9:0]  reveal_sum;
  logic [10:0] col, row;
  logic        in_range, bm_bit, hidden;
  logic [31:0] bit_lin;
  logic [IW-1:0] bit_idx;
  logic [7:0]  hue_col, draw_col;

  // A frame pulse landing on a mode change edge is dropped; the new mode
  // starts from freshly cleared counters.
  assign mode_chg   = (mode != mode_q);
  assign sof        = startOfFrame && !mode_chg;
  assign reveal_sum = 10'(reveal_col_q) + 10'(REVEAL_STEP);

  // Frame and hue counters; each advances only in the mode that uses it.
  always_comb begin
    mode_d      = mode;
    frame_cnt_d = frame_cnt_q;
    div_d       = div_q;
    hue_d       = hue_q;
    if (mode_chg) begin
      frame_cnt_d = 8'd0;
      div_d       = 8'd0;
      hue_d       = 3'd0;
    end else if (sof) begin
      if (mode_q == 2'd1)
        frame_cnt_d = (frame_cnt_q >= 8'(BLINK_PERIOD - 1)) ? 8'd0 : frame_cnt_q + 8'd1;
      if (mode_q == 2'd3) begin
        if (div_q >= 8'(HUE_PERIOD - 1)) begin
          div_d = 8'd0;
          hue_d = hue_q + 3'd1;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
    end
  end

  // Reveal wipe FSM: restarts from column 0 whenever mode becomes 2.
  always_comb begin
    state_d      = state_q;
    reveal_col_d = reveal_col_q;
    if (mode_chg) begin
      reveal_col_d = 9'd0;
      state_d      = (mode == 2'd2) ? RUN : IDLE;
    end else begin
      case (state_q)
        RUN: begin
          if (sof) begin
            if (reveal_sum >= 10'(WIDTH)) begin
              reveal_col_d = 9'(WIDTH);
              state_d      = DONE;
            end else begin
              reveal_col_d = reveal_sum[8:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Pixel lookup, mode masking and colour selection.
  always_comb begin
    col      = offsetX >> SCALE_SHIFT;
    row      = offsetY >> SCALE_SHIFT;
    in_range = (col < 11'(WIDTH)) && (row < 11'(HEIGHT));
    // Row 0 occupies the MSBs, column 0 is the MSB within a row.
    bit_lin  = 32'(NB - 1) - (32'(row) * 32'(WIDTH) + 32'(col));
    bit_idx  = IW'(bit_lin);
    bm_bit   = in_range ? BITMAP[bit_idx] : 1'b1;
    hue_col  = COLOR + {hue_q, 5'b0};
    // An all-zero hue would read as transparent, so fall back to the base colour.
    draw_col = ((mode_q == 2'd3) && (hue_col != 8'h00)) ? hue_col : COLOR;
    hidden   = ((mode_q == 2'd1) && (frame_cnt_q >= 8'(BLINK_ON))) ||
               ((mode_q == 2'd2) && (col >= 11'(reveal_col_q)));
    rgb_d    = (InsideRectangle && !bm_bit && !hidden) ? draw_col : 8'h00;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mode_q       <= 2'd0;
      reveal_col_q <= 9'd0;
      frame_cnt_q  <= 8'd0;
      div_q        <= 8'd0;
      hue_q        <= 3'd0;
      rgb_q        <= 8'h00;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      reveal_col_q <= reveal_col_d;
      frame_cnt_q  <= frame_cnt_d;
      div_q        <= div_d;
      hue_q        <= hue_d;
      rgb_q        <= rgb_d;
    end
  end

  assign RGBout         = rgb_q;
  assign drawingRequest = (rgb_q != 8'h00);
  assign animDone       = (state_q == DONE);

endmodule
